pb_arbiter: RTL and testbench

PB_ARBITER -- requirements
Module: pb_arbiter

---
 rtl/pb_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_pb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_arbiter.sv
// Reaction-game pushbutton arbiter: two debounced buttons race once the round
// LEDs light. Presses made before the LEDs light are counted as fouls.

module pb_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_press
);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } db_state_t;

    // cnt value at which the next stable cycle accepts the new level
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic      r_s1;
    logic      r_s2;
    db_state_t r_state;
    logic [3:0] r_cnt;

    db_state_t w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic      w_press;

    // synchronizer, debounce state and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= RELEASED;
            r_cnt   <= 4'd0;
        end else begin
            r_s1    <= i_pin;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next debounce state; the counter only runs while confirming a change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 4'd0;
        w_press     = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_s2) begin
                    w_state_nxt = CONFIRM_PRESS;
                    w_cnt_nxt   = 4'd1;
                end else begin
                    w_state_nxt = RELEASED;
                end
            end
            CONFIRM_PRESS: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            PRESSED: begin
                if (!r_s2) begin
                    w_state_nxt = CONFIRM_RELEASE;
                    w_cnt_nxt   = 4'd1;
                end else begin
                    w_state_nxt = PRESSED;
                end
            end
            CONFIRM_RELEASE: begin
                if (r_s2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = RELEASED;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
            end
        endcase
    end

    assign o_press = w_press;

endmodule

module pb_arbiter #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       leds_on,
    input  logic       clr_fouls,
    output logic       win_l,
    output logic       win_r,
    output logic       tie,
    output logic       early_l,
    output logic       early_r,
    output logic [1:0] fouls_l,
    output logic [1:0] fouls_r,
    output logic       armed
);

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        if (v == 2'd3) begin
            return 2'd3;
        end else begin
            return v + 2'd1;
        end
    endfunction

    logic w_press_l;
    logic w_press_r;

    logic       r_win_l,   w_win_l_nxt;
    logic       r_win_r,   w_win_r_nxt;
    logic       r_tie,     w_tie_nxt;
    logic       r_early_l, w_early_l_nxt;
    logic       r_early_r, w_early_r_nxt;
    logic [1:0] r_fouls_l, w_fouls_l_nxt;
    logic [1:0] r_fouls_r, w_fouls_r_nxt;
    logic       r_armed,   w_armed_nxt;

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (pbl),
        .o_press (w_press_l)
    );

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (pbr),
        .o_press (w_press_r)
    );

    // round decision: early presses foul, the first live press wins once armed
    always_comb begin
        w_win_l_nxt   = 1'b0;
        w_win_r_nxt   = 1'b0;
        w_tie_nxt     = 1'b0;
        w_early_l_nxt = 1'b0;
        w_early_r_nxt = 1'b0;
        w_armed_nxt   = r_armed;
        if (!leds_on) begin
            w_armed_nxt   = 1'b1;
            w_early_l_nxt = w_press_l;
            w_early_r_nxt = w_press_r;
        end else if (r_armed) begin
            if (w_press_l && w_press_r) begin
                w_tie_nxt   = 1'b1;
                w_armed_nxt = 1'b0;
            end else if (w_press_l) begin
                w_win_l_nxt = 1'b1;
                w_armed_nxt = 1'b0;
            end else if (w_press_r) begin
                w_win_r_nxt = 1'b1;
                w_armed_nxt = 1'b0;
            end else begin
                w_armed_nxt = 1'b1;
            end
        end else begin
            w_armed_nxt = 1'b0;
        end
    end

    // foul counters; a clear wins over a foul on the same cycle
    always_comb begin
        w_fouls_l_nxt = r_fouls_l;
        w_fouls_r_nxt = r_fouls_r;
        if (clr_fouls) begin
            w_fouls_l_nxt = 2'd0;
            w_fouls_r_nxt = 2'd0;
        end else begin
            if (!leds_on && w_press_l) begin
                w_fouls_l_nxt = sat_inc2(r_fouls_l);
            end else begin
                w_fouls_l_nxt = r_fouls_l;
            end
            if (!leds_on && w_press_r) begin
                w_fouls_r_nxt = sat_inc2(r_fouls_r);
            end else begin
                w_fouls_r_nxt = r_fouls_r;
            end
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_l   <= 1'b0;
            r_win_r   <= 1'b0;
            r_tie     <= 1'b0;
            r_early_l <= 1'b0;
            r_early_r <= 1'b0;
            r_fouls_l <= 2'd0;
            r_fouls_r <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_win_l   <= w_win_l_nxt;
            r_win_r   <= w_win_r_nxt;
            r_tie     <= w_tie_nxt;
            r_early_l <= w_early_l_nxt;
            r_early_r <= w_early_r_nxt;
            r_fouls_l <= w_fouls_l_nxt;
            r_fouls_r <= w_fouls_r_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

    assign win_l   = r_win_l;
    assign win_r   = r_win_r;
    assign tie     = r_tie;
    assign early_l = r_early_l;
    assign early_r = r_early_r;
    assign fouls_l = r_fouls_l;
    assign fouls_r = r_fouls_r;
    assign armed   = r_armed;

endmodule

module pb_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic win_l,
    input logic win_r,
    input logic tie,
    input logic armed
);

    a_onehot_result: assert property (@(posedge clk) $onehot0({win_l, win_r, tie}));

    a_win_needs_arm: assert property (@(posedge clk) disable iff (rst)
        (win_l || win_r || tie) |-> $past(armed));

endmodule

// File: tb/tb_pb_arbiter.sv
// Randomized and directed bench for pb_arbiter against a behavioural model of
// the button/round rules.

module tb_pb_arbiter;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pbl = 1'b0;
    logic pbr = 1'b0;
    logic leds_on = 1'b0;
    logic clr_fouls = 1'b0;
    logic win_l, win_r, tie, early_l, early_r, armed;
    logic [1:0] fouls_l, fouls_r;

    int n_tests = 0;
    int n_fail  = 0;

    pb_arbiter #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .pbl       (pbl),
        .pbr       (pbr),
        .leds_on   (leds_on),
        .clr_fouls (clr_fouls),
        .win_l     (win_l),
        .win_r     (win_r),
        .tie       (tie),
        .early_l   (early_l),
        .early_r   (early_r),
        .fouls_l   (fouls_l),
        .fouls_r   (fouls_r),
        .armed     (armed)
    );

    pb_arbiter_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .win_l (win_l),
        .win_r (win_r),
        .tie   (tie),
        .armed (armed)
    );

    always #5 clk = ~clk;

    // reference model state: pin sample pipeline, history of synchronized
    // samples, accepted level and round bookkeeping
    bit        m_sy1 [2];
    bit        m_sy2 [2];
    bit [15:0] m_hist[2];
    bit        m_db  [2];
    int m_win_l, m_win_r, m_tie, m_early_l, m_early_r, m_fouls_l, m_fouls_r, m_armed;

    int edge_n = 0;
    int c_wl, c_wr, c_tie, c_el, c_er;
    int fe_wl, fe_wr, fe_el;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // a level is accepted once the last DB synchronized samples all disagree with it
    task automatic step_button(input int b, input bit pin, output bit press);
        bit all_diff;
        m_hist[b] = {m_hist[b][14:0], m_sy2[b]};
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) begin
            if (m_hist[b][i] == m_db[b]) all_diff = 1'b0;
        end
        press = 1'b0;
        if (all_diff) begin
            m_db[b] = ~m_db[b];
            press   = m_db[b];
        end
        m_sy2[b] = m_sy1[b];
        m_sy1[b] = pin;
    endtask

    task automatic model_step();
        bit pl, pr;
        m_win_l = 0; m_win_r = 0; m_tie = 0; m_early_l = 0; m_early_r = 0;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_sy1[b] = 1'b0; m_sy2[b] = 1'b0; m_hist[b] = 16'd0; m_db[b] = 1'b0;
            end
            m_fouls_l = 0; m_fouls_r = 0; m_armed = 0;
        end else begin
            step_button(0, pbl, pl);
            step_button(1, pbr, pr);
            if (!leds_on) begin
                m_armed   = 1;
                m_early_l = int'(pl);
                m_early_r = int'(pr);
            end else if (m_armed == 1) begin
                if (pl && pr) begin m_tie = 1; m_armed = 0; end
                else if (pl)  begin m_win_l = 1; m_armed = 0; end
                else if (pr)  begin m_win_r = 1; m_armed = 0; end
            end
            if (clr_fouls) begin
                m_fouls_l = 0; m_fouls_r = 0;
            end else begin
                if (!leds_on && pl && m_fouls_l < 3) m_fouls_l++;
                if (!leds_on && pr && m_fouls_r < 3) m_fouls_r++;
            end
        end
    endtask

    task automatic clr_counts();
        c_wl = 0; c_wr = 0; c_tie = 0; c_el = 0; c_er = 0;
        fe_wl = -1; fe_wr = -1; fe_el = -1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        edge_n++;
        chk("win_l",   int'(win_l),   m_win_l);
        chk("win_r",   int'(win_r),   m_win_r);
        chk("tie",     int'(tie),     m_tie);
        chk("early_l", int'(early_l), m_early_l);
        chk("early_r", int'(early_r), m_early_r);
        chk("fouls_l", int'(fouls_l), m_fouls_l);
        chk("fouls_r", int'(fouls_r), m_fouls_r);
        chk("armed",   int'(armed),   m_armed);
        chk("onehot",  int'(win_l) + int'(win_r) + int'(tie) <= 1 ? 1 : 0, 1);
        if (win_l)   begin c_wl++;  if (fe_wl < 0) fe_wl = edge_n; end
        if (win_r)   begin c_wr++;  if (fe_wr < 0) fe_wr = edge_n; end
        if (tie)     c_tie++;
        if (early_l) begin c_el++;  if (fe_el < 0) fe_el = edge_n; end
        if (early_r) c_er++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic arm_round();
        leds_on = 1'b0;
        cycle();
        leds_on = 1'b1;
    endtask

    int rem_l, rem_r, last_rise, rst_last;

    initial begin
        clr_counts();
        run(3);
        chk("rst_win_l",   int'(win_l),   0);
        chk("rst_tie",     int'(tie),     0);
        chk("rst_early_l", int'(early_l), 0);
        chk("rst_fouls_l", int'(fouls_l), 0);
        chk("rst_armed",   int'(armed),   0);

        // first live press after one armed cycle
        rst = 1'b0;
        edge_n = 0;
        arm_round();
        run(8);
        pbl = 1'b1;
        clr_counts();
        run(16);
        chk("req034_win_edge",  fe_wl, 15);
        chk("req034_win_count", c_wl, 1);
        chk("req034_armed",     int'(armed), 0);
        pbl = 1'b0;
        run(10);

        // simultaneous presses
        arm_round();
        run(1);
        clr_counts();
        pbl = 1'b1; pbr = 1'b1;
        run(10);
        chk("req035_tie",   c_tie, 1);
        chk("req035_win_l", c_wl, 0);
        chk("req035_win_r", c_wr, 0);
        pbl = 1'b0; pbr = 1'b0;
        run(10);

        // bouncy right button
        arm_round();
        run(1);
        clr_counts();
        pbr = 1'b1; cycle();
        pbr = 1'b0; cycle();
        pbr = 1'b1; cycle();
        pbr = 1'b0; cycle();
        pbr = 1'b1;
        last_rise = edge_n + 1;
        run(12);
        chk("req036_win_r_count", c_wr, 1);
        chk("req036_latency",     fe_wr - last_rise, DB + 1);
        pbr = 1'b0;
        run(10);

        // presses after the round is decided are ignored until re-armed
        arm_round();
        clr_counts();
        pbl = 1'b1; run(10);
        chk("req038_win_l", c_wl, 1);
        pbl = 1'b0; run(10);
        clr_counts();
        pbr = 1'b1; run(10);
        chk("req038_ignored_win",   c_wr, 0);
        chk("req038_ignored_early", c_er, 0);
        pbr = 1'b0; run(10);
        arm_round();
        clr_counts();
        pbr = 1'b1; run(10);
        chk("req038_rearm_win_r", c_wr, 1);
        pbr = 1'b0; run(10);

        // foul saturation and clear
        leds_on = 1'b0;
        clr_counts();
        for (int i = 0; i < 5; i++) begin
            pbl = 1'b1; run(8);
            pbl = 1'b0; run(8);
        end
        chk("req037_early_count", c_el, 5);
        chk("req037_fouls_sat",   int'(fouls_l), 3);
        clr_fouls = 1'b1; cycle();
        clr_fouls = 1'b0;
        chk("req037_fouls_clr",   int'(fouls_l), 0);

        // reset in the middle of a press confirmation
        clr_counts();
        pbl = 1'b1;
        run(4);
        rst = 1'b1;
        run(2);
        chk("req039_rst_fouls", int'(fouls_l), 0);
        rst = 1'b0;
        rst_last = edge_n;
        run(12);
        chk("req039_early_count", c_el, 1);
        chk("req039_latency",     fe_el - rst_last, DB + 2);
        chk("req039_fouls",       int'(fouls_l), 1);
        pbl = 1'b0;
        run(10);

        // random play
        rem_l = 0; rem_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rem_l == 0) begin
                pbl   = 1'($urandom_range(0, 1));
                rem_l = ($urandom_range(0, 9) < 7) ? $urandom_range(DB + 2, 20)
                                                   : $urandom_range(1, DB);
            end
            if (rem_r == 0) begin
                pbr   = 1'($urandom_range(0, 1));
                rem_r = ($urandom_range(0, 9) < 7) ? $urandom_range(DB + 2, 20)
                                                   : $urandom_range(1, DB);
            end
            rem_l--; rem_r--;
            if ($urandom_range(0, 39) == 0) leds_on = ~leds_on;
            clr_fouls = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        clr_fouls = 1'b0;
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
